// File: rtl/dm_arb_pkg.sv
// Shared types and helpers for the two-port data-memory arbiter.
// Used by the top level and the winner-select sub-module.
package dm_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        ACK   = 2'd2
    } state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    localparam int STARVE_MAX_DEF = 4;
    // Wide enough for the largest legal STARVE_MAX (15).
    localparam int CNT_W = 4;

    // Keep only the DM address bits and force word alignment.
    function automatic logic [31:0] align_addr(input logic [31:0] addr,
                                               input int unsigned abits);
        logic [31:0] mask;
        mask = (abits >= 32) ? 32'hFFFF_FFFF : ((32'd1 << abits) - 32'd1);
        return addr & mask & 32'hFFFF_FFFC;
    endfunction

    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/dm_arb_pick.sv
// Winner select for the DM arbiter: port 0 has priority unless port 1 has
// lost STARVE_MAX contended arbitrations in a row.
module dm_arb_pick
    import dm_arb_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_arb,
    output logic o_grant,
    output logic o_any
);

    logic [CNT_W-1:0] r_starve_cnt;
    logic             w_starved;

    assign w_starved = (r_starve_cnt == CNT_W'(STARVE_MAX));

    always_comb begin
        o_any   = i_req0 | i_req1;
        o_grant = PORT_CPU;
        if (i_req1 && (!i_req0 || w_starved)) begin
            o_grant = PORT_DBG;
        end
    end

    // The counter never passes STARVE_MAX: once it gets there port 1 wins
    // the next contended round, which clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt <= '0;
        end else if (i_arb && o_any) begin
            if (o_grant == PORT_DBG) begin
                r_starve_cnt <= '0;
            end else if (i_req1 && !w_starved) begin
                r_starve_cnt <= r_starve_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// Two-requester arbiter for the single-port word data memory. Each access is
// a three-cycle IDLE -> ISSUE -> ACK transaction ending in a one-cycle ack.
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF,
    parameter int ADDR_BITS  = 12
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [31:0] m0_pc,
    output logic        m0_ack,
    output logic [31:0] m0_rdata,
    output logic        m0_err,

    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic [31:0] m1_rdata,
    output logic        m1_err,

    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic        dm_we,
    output logic [31:0] dm_pc,
    input  logic [31:0] dm_rdata
);

    state_t      r_state;
    logic        r_we;
    logic        r_win;
    logic        r_err;
    logic [31:0] r_dm_addr;
    logic [31:0] r_dm_wdata;
    logic [31:0] r_dm_pc;
    logic        r_m0_ack;
    logic        r_m1_ack;
    logic        r_m0_err;
    logic        r_m1_err;
    logic [31:0] r_m0_rdata;
    logic [31:0] r_m1_rdata;

    logic        w_grant;
    logic        w_any;
    logic        w_arb;
    logic        w_sel_we;
    logic [31:0] w_sel_addr;
    logic [31:0] w_sel_wdata;
    logic [31:0] w_sel_pc;

    assign w_arb = (r_state == IDLE);

    dm_arb_pick #(
        .STARVE_MAX (STARVE_MAX)
    ) u_pick (
        .clk     (clk),
        .rst     (rst),
        .i_req0  (m0_req),
        .i_req1  (m1_req),
        .i_arb   (w_arb),
        .o_grant (w_grant),
        .o_any   (w_any)
    );

    // Request fields of the current winner; port 1 has no PC, so it logs 0.
    always_comb begin
        w_sel_we    = m0_we;
        w_sel_addr  = m0_addr;
        w_sel_wdata = m0_wdata;
        w_sel_pc    = m0_pc;
        if (w_grant == PORT_DBG) begin
            w_sel_we    = m1_we;
            w_sel_addr  = m1_addr;
            w_sel_wdata = m1_wdata;
            w_sel_pc    = 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_we       <= 1'b0;
            r_win      <= PORT_CPU;
            r_err      <= 1'b0;
            r_dm_addr  <= '0;
            r_dm_wdata <= '0;
            r_dm_pc    <= '0;
            r_m0_ack   <= 1'b0;
            r_m1_ack   <= 1'b0;
            r_m0_err   <= 1'b0;
            r_m1_err   <= 1'b0;
            r_m0_rdata <= '0;
            r_m1_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_m0_ack <= 1'b0;
                    r_m1_ack <= 1'b0;
                    r_m0_err <= 1'b0;
                    r_m1_err <= 1'b0;
                    if (w_any) begin
                        r_win      <= w_grant;
                        r_we       <= w_sel_we;
                        r_err      <= is_misaligned(w_sel_addr);
                        r_dm_addr  <= align_addr(w_sel_addr, ADDR_BITS);
                        r_dm_wdata <= w_sel_wdata;
                        r_dm_pc    <= w_sel_pc;
                        r_state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Read data is sampled before the write lands, so a
                    // write returns the old word.
                    if (r_win == PORT_CPU) begin
                        r_m0_rdata <= dm_rdata;
                        r_m0_ack   <= 1'b1;
                        r_m0_err   <= r_err;
                    end else begin
                        r_m1_rdata <= dm_rdata;
                        r_m1_ack   <= 1'b1;
                        r_m1_err   <= r_err;
                    end
                    r_state <= ACK;
                end
                ACK: begin
                    r_m0_ack <= 1'b0;
                    r_m1_ack <= 1'b0;
                    r_m0_err <= 1'b0;
                    r_m1_err <= 1'b0;
                    r_state  <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Gated by rst so a reset landing on ISSUE cannot commit the write.
    assign dm_we    = (r_state == ISSUE) && r_we && !rst;
    assign dm_addr  = r_dm_addr;
    assign dm_wdata = r_dm_wdata;
    assign dm_pc    = r_dm_pc;

    assign m0_ack   = r_m0_ack;
    assign m0_rdata = r_m0_rdata;
    assign m0_err   = r_m0_err;
    assign m1_ack   = r_m1_ack;
    assign m1_rdata = r_m1_rdata;
    assign m1_err   = r_m1_err;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a behavioural 4 KiB word memory on the
// DM side.
module tb_dm_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we;
    logic [31:0] m0_addr, m0_wdata, m0_pc;
    logic        m0_ack, m0_err;
    logic [31:0] m0_rdata;
    logic        m1_req, m1_we;
    logic [31:0] m1_addr, m1_wdata;
    logic        m1_ack, m1_err;
    logic [31:0] m1_rdata;
    logic [31:0] dm_addr, dm_wdata, dm_pc, dm_rdata;
    logic        dm_we;

    logic [31:0] mem [0:1023];
    logic        pl_en;
    logic [9:0]  pl_addr;
    logic [31:0] pl_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dm_arbiter #(.STARVE_MAX(4), .ADDR_BITS(12)) dut (
        .clk      (clk),
        .rst      (rst),
        .m0_req   (m0_req),
        .m0_we    (m0_we),
        .m0_addr  (m0_addr),
        .m0_wdata (m0_wdata),
        .m0_pc    (m0_pc),
        .m0_ack   (m0_ack),
        .m0_rdata (m0_rdata),
        .m0_err   (m0_err),
        .m1_req   (m1_req),
        .m1_we    (m1_we),
        .m1_addr  (m1_addr),
        .m1_wdata (m1_wdata),
        .m1_ack   (m1_ack),
        .m1_rdata (m1_rdata),
        .m1_err   (m1_err),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_we    (dm_we),
        .dm_pc    (dm_pc),
        .dm_rdata (dm_rdata)
    );

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (dm_we) mem[dm_addr[11:2]] <= dm_wdata;
    end

    assign dm_rdata = mem[dm_addr[11:2]];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [9:0] a, input logic [31:0] d);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        tick();
        pl_en   = 1'b0;
    endtask

    logic [9:0] grant_pat;
    int         nack;

    initial begin
        rst = 1'b1;
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0; m0_pc = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
        pl_en = 0; pl_addr = 0; pl_data = 0;
        preload(10'd0,  32'h0);
        preload(10'd4,  32'hDEADBEEF);
        preload(10'd8,  32'h0);
        preload(10'd16, 32'h0);
        tick();

        // Reset state
        chk("rst_m0_ack", 32'(m0_ack), 32'd0);
        chk("rst_m1_ack", 32'(m1_ack), 32'd0);
        chk("rst_dm_we", 32'(dm_we), 32'd0);
        chk("rst_dm_addr", dm_addr, 32'd0);
        chk("rst_dm_pc", dm_pc, 32'd0);
        chk("rst_m0_rdata", m0_rdata, 32'd0);
        rst = 1'b0;
        tick();

        // Port 0 read of 0x10
        m0_req = 1; m0_we = 0; m0_addr = 32'h10; m0_pc = 32'h400;
        tick();
        chk("rd0_issue_addr", dm_addr, 32'h10);
        chk("rd0_issue_pc", dm_pc, 32'h400);
        chk("rd0_issue_we", 32'(dm_we), 32'd0);
        m0_req = 0;
        tick();
        chk("rd0_ack", 32'(m0_ack), 32'd1);
        chk("rd0_rdata", m0_rdata, 32'hDEADBEEF);
        chk("rd0_err", 32'(m0_err), 32'd0);
        chk("rd0_m1_ack", 32'(m1_ack), 32'd0);
        chk("rd0_ack_we", 32'(dm_we), 32'd0);
        tick();
        chk("rd0_ack_drop", 32'(m0_ack), 32'd0);

        // Port 1 write of 0x12345678 to 0x20
        m1_req = 1; m1_we = 1; m1_addr = 32'h20; m1_wdata = 32'h12345678;
        tick();
        chk("wr1_issue_we", 32'(dm_we), 32'd1);
        chk("wr1_issue_addr", dm_addr, 32'h20);
        chk("wr1_issue_pc", dm_pc, 32'd0);
        chk("wr1_issue_wdata", dm_wdata, 32'h12345678);
        m1_req = 0;
        tick();
        chk("wr1_ack", 32'(m1_ack), 32'd1);
        chk("wr1_old_data", m1_rdata, 32'd0);
        chk("wr1_ack_we", 32'(dm_we), 32'd0);
        chk("wr1_m0_ack", 32'(m0_ack), 32'd0);
        chk("wr1_mem", mem[8], 32'h12345678);
        tick();

        // Port 0 reads back 0x20
        m0_req = 1; m0_we = 0; m0_addr = 32'h20;
        tick();
        m0_req = 0;
        tick();
        chk("rb0_ack", 32'(m0_ack), 32'd1);
        chk("rb0_rdata", m0_rdata, 32'h12345678);
        tick();

        // Contention: both requests held; port 1 wins every fifth grant
        grant_pat = 10'b10_0001_0000;
        nack = 0;
        m0_req = 1; m0_we = 0; m0_addr = 32'h10;
        m1_req = 1; m1_we = 0; m1_addr = 32'h20;
        for (int i = 1; i <= 30; i++) begin
            tick();
            chk("cont_not_both", 32'(m0_ack & m1_ack), 32'd0);
            if (m0_ack || m1_ack) begin
                chk("cont_ack_cycle", 32'(i), 32'(2 + 3 * nack));
                if (nack < 10) chk("cont_grant", 32'(m1_ack), 32'(grant_pat[nack]));
                if (m1_ack) chk("cont_m1_rdata", m1_rdata, 32'h12345678);
                else chk("cont_m0_rdata", m0_rdata, 32'hDEADBEEF);
                nack++;
            end
        end
        m0_req = 0; m1_req = 0;
        chk("cont_ack_count", 32'(nack), 32'd10);
        tick();

        // Misaligned read at 0x13
        m0_req = 1; m0_we = 0; m0_addr = 32'h13;
        tick();
        chk("mis_dm_addr", dm_addr, 32'h10);
        m0_req = 0;
        tick();
        chk("mis_ack", 32'(m0_ack), 32'd1);
        chk("mis_err", 32'(m0_err), 32'd1);
        chk("mis_rdata", m0_rdata, 32'hDEADBEEF);
        tick();
        chk("mis_err_clear", 32'(m0_err), 32'd0);

        // Reset during ISSUE of a write to 0x40
        m0_req = 1; m0_we = 1; m0_addr = 32'h40; m0_wdata = 32'hCAFEF00D;
        tick();
        chk("rstw_issue_we", 32'(dm_we), 32'd1);
        rst = 1; m0_req = 0;
        #1;
        chk("rstw_we_forced", 32'(dm_we), 32'd0);
        tick();
        rst = 0;
        chk("rstw_mem", mem[16], 32'd0);
        chk("rstw_ack", 32'(m0_ack), 32'd0);
        chk("rstw_dm_addr", dm_addr, 32'd0);
        chk("rstw_dm_wdata", dm_wdata, 32'd0);
        chk("rstw_dm_pc", dm_pc, 32'd0);
        chk("rstw_m0_rdata", m0_rdata, 32'd0);
        chk("rstw_dm_we", 32'(dm_we), 32'd0);
        tick();
        chk("rstw_no_ack1", 32'(m0_ack), 32'd0);
        tick();
        chk("rstw_no_ack2", 32'(m0_ack), 32'd0);
        chk("rstw_mem2", mem[16], 32'd0);

        // Back-to-back: req held for 9 cycles gives acks at T+2, T+5, T+8
        m0_req = 1; m0_we = 0; m0_addr = 32'h10;
        for (int i = 1; i <= 9; i++) begin
            tick();
            if (i == 9) m0_req = 0;
            chk("b2b_ack", 32'(m0_ack), 32'((i == 2) || (i == 5) || (i == 8)));
            if (i == 8) chk("b2b_rdata", m0_rdata, 32'hDEADBEEF);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("b2b_idle", 32'(m0_ack), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
